// File: rtl/stepper_drive.sv
// stepper_drive: turns (dir, val, done) steering commands into paced bursts of
// full steps on a 4-coil unipolar stepper, tracks absolute mount position,
// enforces soft travel limits and holds off new commands while settling.
module stepper_drive #(
    parameter logic [15:0] STEP_PERIOD   = 16'd50000,
    parameter logic [23:0] SETTLE_CYCLES = 24'd2700000,
    parameter logic [7:0]  MAX_CMD_STEPS = 8'd32,
    parameter logic [9:0]  POS_MIN       = 10'd0,
    parameter logic [9:0]  POS_MAX       = 10'd400,
    parameter logic [9:0]  POS_RESET     = 10'd200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       dir,
    input  logic [7:0] val,
    input  logic       done,
    output logic [3:0] coils,
    output logic [9:0] position,
    output logic       busy,
    output logic       move_done,
    output logic       limit_hit
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_SETTLE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_phase;
    logic [3:0]  r_coils;
    logic [9:0]  r_position;
    logic        r_busy;
    logic        r_move_done;
    logic        r_limit_hit;
    logic        r_dir;
    logic [7:0]  r_remaining;
    logic [15:0] r_step_timer;
    logic [23:0] r_settle_timer;

    logic [1:0]  w_next_phase;
    logic        w_at_limit;
    logic [7:0]  w_cmd_steps;
    logic        w_accept;

    // Full-step drive pattern for each phase index.
    function automatic logic [3:0] phase_coils(input logic [1:0] idx);
        case (idx)
            2'd0:    phase_coils = 4'b1100;
            2'd1:    phase_coils = 4'b0110;
            2'd2:    phase_coils = 4'b0011;
            default: phase_coils = 4'b1001;
        endcase
    endfunction

    // Next phase, limit test and clamped step count for the current command.
    always_comb begin
        w_next_phase = r_dir ? (r_phase - 2'd1) : (r_phase + 2'd1);
        w_at_limit   = r_dir ? (r_position == POS_MIN) : (r_position == POS_MAX);
        w_cmd_steps  = (val > MAX_CMD_STEPS) ? MAX_CMD_STEPS : val;
        w_accept     = enable && done && (val != 8'd0);
    end

    // Move sequencer: accept, pace steps, settle, abort on enable low.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_phase        <= 2'd0;
            r_coils        <= 4'b1100;
            r_position     <= POS_RESET;
            r_busy         <= 1'b0;
            r_move_done    <= 1'b0;
            r_limit_hit    <= 1'b0;
            r_dir          <= 1'b0;
            r_remaining    <= '0;
            r_step_timer   <= '0;
            r_settle_timer <= '0;
        end else begin
            r_move_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_STEP;
                        r_dir        <= dir;
                        r_remaining  <= w_cmd_steps;
                        r_limit_hit  <= 1'b0;
                        r_step_timer <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                S_STEP: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_step_timer == STEP_PERIOD - 16'd1) begin
                        if (w_at_limit) begin
                            r_limit_hit    <= 1'b1;
                            r_state        <= S_SETTLE;
                            r_settle_timer <= '0;
                        end else begin
                            r_phase      <= w_next_phase;
                            r_coils      <= phase_coils(w_next_phase);
                            r_position   <= r_dir ? (r_position - 10'd1) : (r_position + 10'd1);
                            r_remaining  <= r_remaining - 8'd1;
                            r_step_timer <= '0;
                            if (r_remaining == 8'd1) begin
                                r_state        <= S_SETTLE;
                                r_settle_timer <= '0;
                            end
                        end
                    end else begin
                        r_step_timer <= r_step_timer + 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_settle_timer == SETTLE_CYCLES - 24'd1) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_move_done <= 1'b1;
                    end else begin
                        r_settle_timer <= r_settle_timer + 24'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign coils     = r_coils;
    assign position  = r_position;
    assign busy      = r_busy;
    assign move_done = r_move_done;
    assign limit_hit = r_limit_hit;

endmodule

// File: tb/tb_stepper_drive.sv
// tb_stepper_drive: directed and randomized stimulus for stepper_drive, checked
// every cycle against an event-time behavioural model plus literal expectations.
module tb_stepper_drive;

    localparam int P    = 4;
    localparam int S    = 3;
    localparam int MAXS = 32;
    localparam int PMIN = 0;
    localparam int PMAX = 400;
    localparam int PRST = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] val = 8'd0;
    logic       done = 1'b0;
    logic [3:0] coils;
    logic [9:0] position;
    logic       busy;
    logic       move_done;
    logic       limit_hit;

    int n_cmp  = 0;
    int n_fail = 0;

    stepper_drive #(
        .STEP_PERIOD  (16'(P)),
        .SETTLE_CYCLES(24'(S)),
        .MAX_CMD_STEPS(8'(MAXS)),
        .POS_MIN      (10'(PMIN)),
        .POS_MAX      (10'(PMAX)),
        .POS_RESET    (10'(PRST))
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .dir      (dir),
        .val      (val),
        .done     (done),
        .coils    (coils),
        .position (position),
        .busy     (busy),
        .move_done(move_done),
        .limit_hit(limit_hit)
    );

    always #5 clock = ~clock;

    // Model: mode 0 idle, 1 moving, 2 settling; m_next is the absolute cycle
    // number of the next scheduled event (a step or the end of settling).
    int     m_mode  = 0;
    int     m_pos   = PRST;
    int     m_idx   = 0;
    int     m_left  = 0;
    int     m_dir   = 0;
    int     m_limit = 0;
    int     m_busy  = 0;
    int     m_mdone = 0;
    longint now     = 0;
    longint m_next  = 0;

    function automatic int coil_of(input int idx);
        case (idx)
            0:       return 4'b1100;
            1:       return 4'b0110;
            2:       return 4'b0011;
            default: return 4'b1001;
        endcase
    endfunction

    task automatic model_step();
        now++;
        m_mdone = 0;
        if (reset) begin
            m_mode = 0; m_pos = PRST; m_idx = 0; m_left = 0;
            m_dir = 0; m_limit = 0; m_busy = 0;
        end else if (m_mode == 0) begin
            if (enable && done && val != 0) begin
                m_mode  = 1;
                m_dir   = int'(dir);
                m_left  = (int'(val) > MAXS) ? MAXS : int'(val);
                m_limit = 0;
                m_busy  = 1;
                m_next  = now + P;
            end
        end else if (!enable) begin
            m_mode = 0;
            m_busy = 0;
        end else if (m_mode == 1) begin
            if (now == m_next) begin
                if ((m_dir == 0 && m_pos == PMAX) || (m_dir == 1 && m_pos == PMIN)) begin
                    m_limit = 1;
                    m_mode  = 2;
                    m_next  = now + S;
                end else begin
                    m_idx  = (m_idx + (m_dir != 0 ? 3 : 1)) % 4;
                    m_pos  = m_pos + (m_dir != 0 ? -1 : 1);
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_mode = 2;
                        m_next = now + S;
                    end else begin
                        m_next = now + P;
                    end
                end
            end
        end else begin
            if (now == m_next) begin
                m_mode  = 0;
                m_busy  = 0;
                m_mdone = 1;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, now);
        end
    endtask

    task automatic compare_all();
        check("coils",     int'(coils),     coil_of(m_idx));
        check("position",  int'(position),  m_pos);
        check("busy",      int'(busy),      m_busy);
        check("move_done", int'(move_done), m_mdone);
        check("limit_hit", int'(limit_hit), m_limit);
    endtask

    // One clock: advance the model with the inputs sampled at the edge, then compare.
    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        reset = 1'b0;
    endtask

    task automatic issue(input logic d, input logic [7:0] v);
        enable = 1'b1;
        dir    = d;
        val    = v;
        done   = 1'b1;
        cycle();
        done   = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int pulses);
        int k;
        k = 0;
        pulses = 0;
        while (busy && k < bound) begin
            cycle();
            if (move_done) pulses++;
            k++;
        end
        if (busy) check("wait_idle_timeout", 1, 0);
    endtask

    initial begin
        int pulses;

        // Reset
        do_reset(2);
        check("rst_coils", int'(coils), 4'b1100);
        check("rst_pos",   int'(position), 200);
        check("rst_busy",  int'(busy), 0);
        check("rst_mdone", int'(move_done), 0);
        check("rst_limit", int'(limit_hit), 0);

        // Right move of 3 steps
        issue(1'b0, 8'd3);
        for (int k = 1; k <= 16; k++) begin
            cycle();
            if (k == 4)  begin check("rm_pos1", int'(position), 201); check("rm_coil1", int'(coils), 4'b0110); end
            if (k == 8)  begin check("rm_pos2", int'(position), 202); check("rm_coil2", int'(coils), 4'b0011); end
            if (k == 12) begin check("rm_pos3", int'(position), 203); check("rm_coil3", int'(coils), 4'b1001); end
            check("rm_mdone", int'(move_done), (k == 15) ? 1 : 0);
            check("rm_busy",  int'(busy), (k <= 14) ? 1 : 0);
        end

        // Left move, clamped to 32 steps, phase wraps 0 -> 3
        do_reset(2);
        issue(1'b1, 8'd200);
        for (int k = 0; k < 4; k++) cycle();
        check("lm_wrap_coil", int'(coils), 4'b1001);
        check("lm_wrap_pos",  int'(position), 199);
        wait_idle(300, pulses);
        check("lm_pulses", pulses, 1);
        check("lm_pos",    int'(position), 168);

        // Walk to 398, then hit the upper limit
        do_reset(1);
        for (int c = 0; c < 6; c++) begin
            issue(1'b0, 8'd32);
            wait_idle(300, pulses);
        end
        issue(1'b0, 8'd6);
        wait_idle(300, pulses);
        check("lim_start", int'(position), 398);
        issue(1'b0, 8'd5);
        wait_idle(300, pulses);
        check("lim_pos",    int'(position), 400);
        check("lim_flag",   int'(limit_hit), 1);
        check("lim_pulses", pulses, 1);

        // Inputs toggled during a move are ignored
        issue(1'b1, 8'd3);
        for (int k = 0; k < 100 && busy; k++) begin
            done = 1'($urandom);
            val  = 8'($urandom);
            dir  = 1'($urandom);
            cycle();
        end
        done = 1'b0;
        check("ign_pos",   int'(position), 397);
        check("ign_limit", int'(limit_hit), 0);

        // done with val = 0 is ignored
        val  = 8'd0;
        done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("val0_busy", int'(busy), 0);
        end
        done = 1'b0;

        // Abort after first step
        do_reset(1);
        issue(1'b0, 8'd10);
        for (int k = 0; k < 4; k++) cycle();
        check("ab_pos1", int'(position), 201);
        enable = 1'b0;
        cycle();
        check("ab_busy", int'(busy), 0);
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("ab_mdone", int'(move_done), 0);
        end
        check("ab_pos", int'(position), 201);
        enable = 1'b1;

        // Reset mid-move
        issue(1'b0, 8'd10);
        for (int k = 0; k < 6; k++) cycle();
        check("mr_pos_pre", int'(position), 202);
        do_reset(1);
        check("mr_pos",   int'(position), 200);
        check("mr_coils", int'(coils), 4'b1100);
        check("mr_busy",  int'(busy), 0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            int r;
            reset  = ($urandom_range(0, 599) == 0);
            enable = ($urandom_range(0, 99) < 95);
            done   = ($urandom_range(0, 3) == 0);
            dir    = 1'($urandom);
            r      = $urandom_range(0, 9);
            if (r < 2)      val = 8'd0;
            else if (r < 8) val = 8'($urandom_range(1, 8));
            else            val = 8'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stepper_drive.md
Name: stepper_drive

Overview:
- Consumes the (dir, val, done) steering command from the audio L/R imbalance stage.
- Turns each accepted command into a paced burst of full steps on a 4-coil unipolar stepper that rotates the microphone/camera mount.
- Tracks absolute mount position, enforces soft travel limits, and holds off new commands until the move has mechanically settled.

Parameters:
- STEP_PERIOD, 16'd50000: clock cycles per step (>=2).
- SETTLE_CYCLES, 24'd2700000: post-move dead time before the next command is accepted (>=1).
- MAX_CMD_STEPS, 8'd32: clamp on steps taken per command.
- POS_MIN, 10'd0: lower soft limit.
- POS_MAX, 10'd400: upper soft limit.
- POS_RESET, 10'd200: position value loaded at reset (mount centred).

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clock
- enable  in  1  motion enable; low blocks acceptance and aborts an active move
- dir  in  1  0 = step right (position +1), 1 = step left (position -1)
- val  in  8  requested step count
- done  in  1  command valid; level, sampled only in IDLE
- coils  out  4  coil drive pattern, registered
- position  out  10  current absolute position, unsigned
- busy  out  1  high in STEP and SETTLE
- move_done  out  1  one-cycle pulse when a move completes
- limit_hit  out  1  sticky: last move was truncated by a soft limit

Behaviour:
- Reset values:
  - state IDLE
  - coils=4'b1100, phase index 0
  - position=POS_RESET
  - busy=0, move_done=0, limit_hit=0
  - step timer, remaining count and settle timer all 0
- Phase table, index 0..3: 1100, 0110, 0011, 1001.
  - dir=0: index+1 mod 4. dir=1: index-1 mod 4, so 0 wraps to 3.
  - Coils change only on a step; coils hold between steps, in IDLE and in SETTLE.
- IDLE:
  - Accept when enable && done && val!=0.
  - On accept, latch dir, set remaining=min(val, MAX_CMD_STEPS), clear limit_hit, step timer=0, go to STEP. busy=1 from the next cycle.
  - done with val=0 is ignored; state stays IDLE.
- STEP:
  - The step timer counts 0..STEP_PERIOD-1. On the cycle the timer equals STEP_PERIOD-1, evaluate the step.
  - If the latched dir would move position beyond POS_MAX (dir=0, position==POS_MAX) or below POS_MIN (dir=1, position==POS_MIN): no step, set limit_hit=1, go to SETTLE.
  - Otherwise update phase and coils, position±1, remaining-1, timer=0. If remaining reaches 0, go to SETTLE.
  - Registered outputs: the first step is visible STEP_PERIOD cycles after the accept edge; each later step follows STEP_PERIOD cycles after the previous one.
  - done, val and dir changes during STEP are ignored.
- SETTLE:
  - Count SETTLE_CYCLES cycles, then go to IDLE.
  - On the transition edge, move_done=1 for exactly one cycle and busy=0 in that same cycle.
  - A command presented in that first IDLE cycle may be accepted in that cycle.
- enable low in STEP or SETTLE: return to IDLE on the next edge.
  - No further steps; coils and position hold.
  - move_done is not pulsed; limit_hit is unchanged.
- Arithmetic:
  - position is unsigned and never leaves [POS_MIN, POS_MAX]; the limit check happens before the update, so no wrap is possible.
  - Comparisons are unsigned.
- Reset mid-move: all state returns to reset values on that edge. Position is re-centred to POS_RESET; no recalibration is required.

Test Plan:
(All tests use STEP_PERIOD=4, SETTLE_CYCLES=3, MAX_CMD_STEPS=32, POS_MIN=0, POS_MAX=400, POS_RESET=200.)
- Reset: hold reset 2 cycles -> coils=1100, position=200, busy=0, move_done=0, limit_hit=0.
- Right move: enable=1, one-cycle done with dir=0, val=3, accepted at edge T0.
  - position reads 201/202/203 at T0+4/T0+8/T0+12.
  - coils read 0110/0011/1001 at T0+4/T0+8/T0+12.
  - move_done pulses at T0+15 only; busy is high T0+1..T0+14.
- Left move with wrap and clamp: dir=1, val=200.
  - Exactly 32 steps; position ends at 168.
  - coils step back through 1001 after 1100.
  - move_done pulses once.
- Limit: from position 398, dir=0, val=5.
  - Steps to 399 and 400, then limit_hit=1.
  - Ends in SETTLE, then move_done pulses.
  - position stays 400.
- Busy ignore and val=0:
  - Toggling done/val/dir during STEP does not change the step count or direction.
  - done with val=0 in IDLE keeps busy=0.
- Abort and reset:
  - enable=0 after the first step of val=10: IDLE on the next edge, position=201, no move_done.
  - reset asserted mid-STEP: position=200, coils=1100.
